sram_burst_reader: RTL and testbench
====================================

Name: sram_burst_reader

Overview:
- Read initiator that drives the single-port SRAM macro interface (CLK, CEB, WEB, A, D, Q).
- Accepts a burst command (start address, word count) and issues one read per cycle to the SRAM.
- Returns the read words on a valid/ready stream, with a last-word flag.
- Sits between the SRAM macro and streaming consumers (e.g. weight/activation fetch); absorbs the SRAM's 1-cycle read latency and consumer backpressure.

Parameters:
- numWord, 1024, SRAM depth in words.
- numBit, 32, SRAM word width.
- numWordAddr, $clog2(numWord), SRAM address width.
- LEN_W, numWordAddr+1, width of burst length field (max burst = numWord).
- FIFO_DEPTH, 3, return-buffer entries (fixed minimum 3; smaller not supported).

Ports:
- CLK  input  1  clock; all state on rising edge.
- RSTN  input  1  asynchronous active-low reset.
- cmd_valid  input  1  burst command valid.
- cmd_ready  output  1  high only in IDLE.
- cmd_addr  input  numWordAddr  first word address.
- cmd_len  input  LEN_W  number of words to read.
- out_valid  output  1  read data valid.
- out_ready  input  1  consumer accepts data.
- out_data  output  numBit  read word.
- out_last  output  1  out_data is final word of burst.
- busy  output  1  high in RUN or DRAIN.
- CEB  output  1  SRAM chip enable, active low.
- WEB  output  1  SRAM write enable, active low; tied 1.
- A  output  numWordAddr  SRAM address.
- D  output  numBit  SRAM write data; tied 0.
- Q  input  numBit  SRAM read data, valid the cycle after CEB=0 is sampled.

Behaviour:
- Reset (async, RSTN=0): state=IDLE; FIFO empty; inflight=0; CEB=1, A=0, out_valid=0, out_last=0, busy=0, cmd_ready=1 (after release). Reset mid-burst aborts immediately; no further reads are issued and buffered data is discarded.
- States: IDLE, RUN, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid at an edge, load addr and remaining=cmd_len.
  - cmd_len=0: accept, no reads, stay IDLE.
  - Otherwise go to RUN.
- RUN: issue a read (CEB=0, A=addr) in a cycle iff remaining>0 and fifo_count+inflight < FIFO_DEPTH.
  - Each issue: addr<=addr+1 modulo numWord (wraps 1023 to 0), remaining--, inflight set for the next cycle.
  - When the last read issues, go to DRAIN.
- DRAIN: no issues. Go to IDLE on the edge where the word with out_last is handshaken.
- CEB and A are driven from registers/state only. There is no combinational path from out_ready or cmd_valid to CEB/A.
- Return path: Q is pushed into the FIFO at the edge after the issuing cycle. Each FIFO entry carries a last bit, set on the final word of the burst. out_valid = FIFO non-empty; out_data/out_last come from the FIFO head; pop on out_valid&out_ready.
- Latency: cmd accepted at edge E0; CEB=0 during cycle E0–E1; out_valid=1 after E2 (2 cycles).
- Throughput: with out_ready held high, one word per cycle sustained.
- Backpressure: out_ready=0 stalls issue once fifo_count+inflight=3. The FIFO never overflows. out_data stays stable while out_valid&!out_ready.
- Simultaneous push and pop in one cycle: count unchanged.
- out_last is asserted only together with out_valid.

Test Plan:
- Reset, then cmd addr=0x010, len=4, out_ready=1 -> CEB low 4 consecutive cycles at A=0x010..0x013; out_valid 2 cycles after accept; 4 words match SRAM contents; out_last on 4th only; cmd_ready back high after last handshake.
- len=0 command -> accepted in 1 cycle; CEB stays 1; no out_valid; busy stays 0.
- Wrap: addr=0x3FE, len=4 -> A sequence 0x3FE, 0x3FF, 0x000, 0x001; data in that order.
- Backpressure: len=8, out_ready=0 for 10 cycles then 1 -> exactly 3 reads issued before the stall; out_data held stable; all 8 words delivered in order with no loss or duplication.
- Random out_ready (50%), len=1024 -> 1024 words; order and data correct; out_last only on word 1024; occupancy never exceeds 3.
- RSTN pulsed low mid-burst (after 5 of 16 words) -> CEB=1 and out_valid=0 immediately; IDLE with cmd_ready=1 after release; a new burst runs correctly.

Source files
------------

// File: rtl/sram_burst_reader.sv
// Burst read initiator for a single-port SRAM macro: issues one read per cycle
// and returns the words on a valid/ready stream through a small return buffer.
module sram_burst_reader #(
    parameter int numWord     = 1024,
    parameter int numBit      = 32,
    parameter int numWordAddr = $clog2(numWord),
    parameter int LEN_W       = numWordAddr + 1,
    parameter int FIFO_DEPTH  = 3
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [numWordAddr-1:0] cmd_addr,
    input  logic [LEN_W-1:0]       cmd_len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [numBit-1:0]      out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   CEB,
    output logic                   WEB,
    output logic [numWordAddr-1:0] A,
    output logic [numBit-1:0]      D,
    input  logic [numBit-1:0]      Q
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [numWordAddr-1:0] addr_q;
    logic [LEN_W-1:0]       remaining_q;
    logic                   inflight_q;
    logic                   inflight_last_q;

    logic [numBit-1:0]      fifo_data [FIFO_DEPTH];
    logic                   fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       fifo_count;

    logic                   accept, issue, last_issue, push, pop;
    logic [OCC_W-1:0]       occupancy;

    // Issue decision uses only registered state, so CEB/A never see out_ready or cmd_valid.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        issue      = 1'b0;
        last_issue = 1'b0;
        occupancy  = OCC_W'(fifo_count) + OCC_W'(inflight_q);
        push       = inflight_q;
        pop        = (fifo_count != '0) && out_ready;
        case (state)
            IDLE: begin
                accept = cmd_valid;
                if (cmd_valid && (cmd_len != '0)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                issue      = (remaining_q != '0) && (occupancy < OCC_W'(FIFO_DEPTH));
                last_issue = issue && (remaining_q == LEN_W'(1));
                if (last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && fifo_last[rd_ptr]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= last_issue;
            if (accept) begin
                addr_q      <= cmd_addr;
                remaining_q <= cmd_len;
            end else if (issue) begin
                addr_q      <= (addr_q == numWordAddr'(numWord - 1)) ? '0 : addr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
            end
        end
    end

    // Return buffer payload needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_data[wr_ptr] <= Q;
            fifo_last[wr_ptr] <= inflight_last_q;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = out_valid && fifo_last[rd_ptr];
    assign CEB       = ~issue;
    assign A         = addr_q;
    assign WEB       = 1'b1;
    assign D         = '0;

endmodule

// File: tb/tb_sram_burst_reader.sv
// Randomized bench for sram_burst_reader: an SRAM model plus an expected-word
// scoreboard built from burst address arithmetic, checked on every handshake.
module tb_sram_burst_reader;

    localparam int numWord     = 1024;
    localparam int numBit      = 32;
    localparam int numWordAddr = 10;
    localparam int LEN_W       = 11;

    logic                   CLK = 1'b0;
    logic                   RSTN = 1'b0;
    logic                   cmd_valid = 1'b0;
    logic [numWordAddr-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]       cmd_len = '0;
    logic                   out_ready = 1'b0;
    logic                   cmd_ready, out_valid, out_last, busy, CEB, WEB;
    logic [numBit-1:0]      out_data, D, Q;
    logic [numWordAddr-1:0] A;

    logic [numBit-1:0] mem [numWord];
    logic [numBit-1:0] q_reg;

    int n_checks = 0;
    int n_fails = 0;
    int cycle_cnt = 0;
    int issues_total = 0;
    int hs_total = 0;
    int max_occ = 0;
    int burst_issues = 0;
    int burst_hs = 0;
    int first_issue_cycle = 0;
    int last_issue_cycle = 0;
    int accept_cycle = 0;
    bit mon_en = 1'b0;
    bit hold_pending = 1'b0;
    logic [numBit-1:0] hold_data = '0;
    bit rand_ready = 1'b0;
    bit forced_ready = 1'b1;

    int               exp_addr_q [$];
    logic [numBit-1:0] exp_data_q [$];
    bit               exp_last_q [$];

    sram_burst_reader #(
        .numWord(numWord), .numBit(numBit), .numWordAddr(numWordAddr),
        .LEN_W(LEN_W), .FIFO_DEPTH(3)
    ) dut (
        .CLK(CLK), .RSTN(RSTN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy),
        .CEB(CEB), .WEB(WEB), .A(A), .D(D), .Q(Q)
    );

    always #5 CLK = ~CLK;

    // SRAM macro: read data appears the cycle after CEB=0 is sampled.
    always @(posedge CLK) begin
        if (!CEB) q_reg <= mem[A];
    end
    assign Q = q_reg;

    always @(posedge CLK) cycle_cnt++;

    always @(posedge CLK) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : forced_ready;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard: SRAM address order, returned words, last flag, hold under stall, occupancy.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (CEB == 1'b0) begin
                issues_total++;
                burst_issues++;
                if (burst_issues == 1) first_issue_cycle = cycle_cnt;
                last_issue_cycle = cycle_cnt;
                if (exp_addr_q.size() == 0) checkOutput("unexpected_issue", 64'd1, 64'd0);
                else checkOutput("sram_addr", 64'(A), 64'(exp_addr_q.pop_front()));
            end
            if (issues_total - hs_total > max_occ) max_occ = issues_total - hs_total;
            if (hold_pending) begin
                checkOutput("hold_valid", 64'(out_valid), 64'd1);
                checkOutput("hold_data", 64'(out_data), 64'(hold_data));
            end
            if (out_last && !out_valid) checkOutput("last_without_valid", 64'd1, 64'd0);
            if (out_valid && out_ready) begin
                hs_total++;
                burst_hs++;
                if (exp_data_q.size() == 0) checkOutput("extra_word", 64'd1, 64'd0);
                else begin
                    checkOutput("out_data", 64'(out_data), 64'(exp_data_q.pop_front()));
                    checkOutput("out_last", 64'(out_last), 64'(exp_last_q.pop_front()));
                end
            end
            hold_pending = out_valid && !out_ready;
            hold_data    = out_data;
        end
    end

    // Waits for cmd_ready, presents one command for one edge and queues the expected burst.
    task automatic applyStimulus(input int a, input int l);
        int waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(posedge CLK); #1;
            waited++;
        end
        checkOutput("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        for (int i = 0; i < l; i++) begin
            exp_addr_q.push_back((a + i) % numWord);
            exp_data_q.push_back(mem[(a + i) % numWord]);
            exp_last_q.push_back(i == l - 1);
        end
        burst_issues = 0;
        burst_hs     = 0;
        cmd_valid = 1'b1;
        cmd_addr  = numWordAddr'(a);
        cmd_len   = LEN_W'(l);
        @(posedge CLK); #1;
        accept_cycle = cycle_cnt;
        cmd_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget, input int l);
        int n = 0;
        while ((busy || out_valid || !cmd_ready) && n < budget) begin
            @(posedge CLK); #1;
            n++;
        end
        checkOutput("idle_timeout", 64'(n < budget), 64'd1);
        checkOutput("words_pending", 64'(exp_data_q.size()), 64'd0);
        checkOutput("addrs_pending", 64'(exp_addr_q.size()), 64'd0);
        checkOutput("burst_words", 64'(burst_hs), 64'(l));
        checkOutput("burst_reads", 64'(burst_issues), 64'(l));
    endtask

    task automatic setReady(input bit random_mode, input bit level);
        rand_ready   = random_mode;
        forced_ready = level;
        repeat (2) begin
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        for (int i = 0; i < numWord; i++) mem[i] = $urandom;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int a;
        int n;

        // Reset values
        repeat (3) @(negedge CLK);
        checkOutput("rst_ceb", 64'(CEB), 64'd1);
        checkOutput("rst_a", 64'(A), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_last", 64'(out_last), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_web", 64'(WEB), 64'd1);
        checkOutput("rst_d", 64'(D), 64'd0);
        @(posedge CLK); #1;
        RSTN = 1'b1;
        @(negedge CLK);
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        mon_en = 1'b1;
        @(posedge CLK); #1;

        // Directed burst with latency and back-to-back issue checks
        applyStimulus(16, 4);
        @(negedge CLK);
        checkOutput("lat_ceb_e0", 64'(CEB), 64'd0);
        checkOutput("lat_a_e0", 64'(A), 64'h010);
        checkOutput("lat_cmd_ready_run", 64'(cmd_ready), 64'd0);
        checkOutput("lat_busy_run", 64'(busy), 64'd1);
        checkOutput("lat_valid_e0", 64'(out_valid), 64'd0);
        @(negedge CLK);
        checkOutput("lat_valid_e1", 64'(out_valid), 64'd0);
        @(negedge CLK);
        checkOutput("lat_valid_e2", 64'(out_valid), 64'd1);
        waitIdle(50, 4);
        checkOutput("first_issue_cycle", 64'(first_issue_cycle), 64'(accept_cycle));
        checkOutput("issue_span", 64'(last_issue_cycle - first_issue_cycle), 64'd3);

        // Zero-length command
        applyStimulus(291, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checkOutput("len0_ceb", 64'(CEB), 64'd1);
            checkOutput("len0_valid", 64'(out_valid), 64'd0);
            checkOutput("len0_busy", 64'(busy), 64'd0);
            checkOutput("len0_cmd_ready", 64'(cmd_ready), 64'd1);
        end
        checkOutput("len0_reads", 64'(burst_issues), 64'd0);
        @(posedge CLK); #1;

        // Address wrap
        applyStimulus(1022, 4);
        waitIdle(50, 4);

        // Backpressure: three reads then stall
        setReady(1'b0, 1'b0);
        a = $urandom_range(0, numWord - 1);
        applyStimulus(a, 8);
        repeat (10) begin
            @(posedge CLK); #1;
        end
        checkOutput("bp_reads_before_stall", 64'(burst_issues), 64'd3);
        checkOutput("bp_words_before_release", 64'(burst_hs), 64'd0);
        forced_ready = 1'b1;
        waitIdle(100, 8);

        // Long burst with random consumer
        setReady(1'b1, 1'b1);
        a = $urandom_range(0, numWord - 1);
        applyStimulus(a, 1024);
        waitIdle(20000, 1024);

        // Short random bursts
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, 40);
            a = $urandom_range(0, numWord - 1);
            applyStimulus(a, n);
            waitIdle(1000, n);
        end

        // Reset in the middle of a burst
        setReady(1'b0, 1'b1);
        a = $urandom_range(0, numWord - 1);
        applyStimulus(a, 16);
        n = 0;
        while (burst_hs < 5 && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        checkOutput("mid_burst_words", 64'(burst_hs), 64'd5);
        mon_en = 1'b0;
        RSTN = 1'b0;
        #1;
        checkOutput("midrst_ceb", 64'(CEB), 64'd1);
        checkOutput("midrst_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_last", 64'(out_last), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_last_q.delete();
        hold_pending = 1'b0;
        issues_total = 0;
        hs_total     = 0;
        repeat (2) begin
            @(posedge CLK); #1;
        end
        RSTN = 1'b1;
        @(negedge CLK);
        checkOutput("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("midrst_idle_ceb", 64'(CEB), 64'd1);
        mon_en = 1'b1;
        @(posedge CLK); #1;
        a = $urandom_range(0, numWord - 1);
        applyStimulus(a, 16);
        waitIdle(200, 16);

        checkOutput("max_occupancy_le3", 64'(max_occ <= 3), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
